// File: rtl/harness_pkg.sv
// harness_pkg: shared register map, FSM states and constants for the project switch sequencer
package harness_pkg;
   localparam logic [3:0] REG_SELECT = 4'h0;
   localparam logic [3:0] REG_OEB0   = 4'h4;
   localparam logic [3:0] REG_OEB1   = 4'h8;
   localparam logic [3:0] REG_HOLD   = 4'hC;
   localparam int STAT_ERR_RANGE = 31;
   localparam int STAT_ERR_BUSY  = 30;
   localparam int STAT_BUSY      = 29;
   localparam logic [7:0] HOLD_RESET = 8'd16;
   typedef enum logic [2:0] {IDLE, ISOLATE, HOLD, SWITCH, ENABLE} state_t;
endpackage

// File: rtl/project_switch_ctrl_if.sv
// project_switch_ctrl_if: Wishbone slave bus between harness master and the switch sequencer
// ports: stb/cyc/we/sel/adr/dat_i from master; ack/dat_o from slave
interface project_switch_ctrl_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                   input  wbs_ack_o, wbs_dat_o);
   modport slave  (input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                   output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/project_switch_regs.sv
// project_switch_regs: Wishbone decode, one-cycle ack, staged OEB/HOLD registers and error bits
// ports: wb (slave bus), busy/active_project (status in), staged_oeb/hold_cycles (staging out),
//        sel_req/sel_target (accepted switch request, combinational in the sampling cycle)
module project_switch_regs
   import harness_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
   parameter int          NUM_PROJECTS = 7,
   parameter int          IO_PADS      = 38
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   project_switch_ctrl_if.slave   wb,
   input  logic                   busy,
   input  logic [7:0]             active_project,
   output logic [IO_PADS-1:0]     staged_oeb,
   output logic [7:0]             hold_cycles,
   output logic                   sel_req,
   output logic [7:0]             sel_target
);
   localparam logic [7:0] NP = 8'(NUM_PROJECTS);
   logic        err_range, err_busy;
   logic        hit, acc, wr, wr_select;
   logic [3:0]  off;
   logic [31:0] rdata;
   assign off        = wb.wbs_adr_i[3:0];
   assign hit        = {wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0]} == {BASE_ADDR[31:4], 2'b00};
   assign acc        = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o & hit;
   assign wr         = acc & wb.wbs_we_i & (wb.wbs_sel_i == 4'hF);
   assign wr_select  = wr & (off == REG_SELECT);
   assign sel_target = wb.wbs_dat_i[7:0];
   assign sel_req    = wr_select & ~busy & (sel_target < NP);
   always_comb begin
      rdata = '0;
      if (off == REG_SELECT) begin
         rdata[7:0]            = active_project;
         rdata[STAT_BUSY]      = busy;
         rdata[STAT_ERR_BUSY]  = err_busy;
         rdata[STAT_ERR_RANGE] = err_range;
      end else
         rdata = off == REG_OEB0 ? staged_oeb[31:0] :
                 off == REG_OEB1 ? 32'(staged_oeb[IO_PADS-1:32]) : {24'b0, hold_cycles};
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb.wbs_ack_o <= 1'b0;
         wb.wbs_dat_o <= '0;
         staged_oeb   <= '1;
         hold_cycles  <= HOLD_RESET;
         err_range    <= 1'b0;
         err_busy     <= 1'b0;
      end else begin
         wb.wbs_ack_o <= acc;
         wb.wbs_dat_o <= (acc & ~wb.wbs_we_i) ? rdata : '0;
         // every SELECT write clears both errors, then flags only the one that applies
         if (wr_select) begin
            err_range <= ~busy & (sel_target >= NP);
            err_busy  <= busy;
         end
         if (wr && off == REG_OEB0) staged_oeb[31:0] <= wb.wbs_dat_i;
         if (wr && off == REG_OEB1) staged_oeb[IO_PADS-1:32] <= wb.wbs_dat_i[IO_PADS-33:0];
         if (wr && off == REG_HOLD) hold_cycles <= wb.wbs_dat_i[7:0];
      end
   end
endmodule

// File: rtl/project_switch_ctrl.sv
// project_switch_ctrl: sequencer that isolates pads, holds resets, swaps project select, then re-enables pads
// ports: wb_clk_i/wb_rst_i (clock, sync active-high reset), wb (Wishbone slave),
//        active_project (pad mux select), io_oeb (active-low enables), project_rst (per-project reset), busy
module project_switch_ctrl
   import harness_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
   parameter int          NUM_PROJECTS = 7,
   parameter int          IO_PADS      = 38
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   project_switch_ctrl_if.slave    wb,
   output logic [7:0]              active_project,
   output logic [IO_PADS-1:0]      io_oeb,
   output logic [NUM_PROJECTS-1:0] project_rst,
   output logic                    busy
);
   state_t                  state, state_nx;
   logic [7:0]              target, target_nx, cnt, cnt_nx, ap_nx, hold_cycles, sel_target;
   logic [IO_PADS-1:0]      staged_oeb, oeb_nx;
   logic [NUM_PROJECTS-1:0] prst_nx;
   logic                    sel_req;
   assign busy = state != IDLE;
   project_switch_regs #(
      .BASE_ADDR(BASE_ADDR), .NUM_PROJECTS(NUM_PROJECTS), .IO_PADS(IO_PADS)
   ) u_regs (
      .wb_clk_i      (wb_clk_i),
      .wb_rst_i      (wb_rst_i),
      .wb            (wb),
      .busy          (busy),
      .active_project(active_project),
      .staged_oeb    (staged_oeb),
      .hold_cycles   (hold_cycles),
      .sel_req       (sel_req),
      .sel_target    (sel_target)
   );
   // reset lands in ISOLATE with target 0 so project 0 is released automatically
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state          <= ISOLATE;
         target         <= '0;
         cnt            <= '0;
         active_project <= '0;
         io_oeb         <= '1;
         project_rst    <= '1;
      end else begin
         state          <= state_nx;
         target         <= target_nx;
         cnt            <= cnt_nx;
         active_project <= ap_nx;
         io_oeb         <= oeb_nx;
         project_rst    <= prst_nx;
      end
   end
   always_comb begin
      state_nx  = state;
      target_nx = target;
      cnt_nx    = cnt;
      ap_nx     = active_project;
      oeb_nx    = io_oeb;
      prst_nx   = project_rst;
      case (state)
         IDLE: if (sel_req) begin
            state_nx  = ISOLATE;
            target_nx = sel_target;
         end
         ISOLATE: begin
            oeb_nx   = '1;
            prst_nx  = '1;
            cnt_nx   = hold_cycles == 8'd0 ? 8'd1 : hold_cycles;
            state_nx = HOLD;
         end
         HOLD: begin
            cnt_nx   = cnt - 8'd1;
            state_nx = cnt <= 8'd1 ? SWITCH : HOLD;
         end
         SWITCH: begin
            ap_nx    = target;
            state_nx = ENABLE;
         end
         ENABLE: begin
            oeb_nx   = staged_oeb;
            prst_nx  = ~(NUM_PROJECTS'(1) << target);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_project_switch_ctrl.sv
// tb_project_switch_ctrl: directed self-checking bench for the project switch sequencer
module tb_project_switch_ctrl;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [63:0] OEB_ALL = 64'h3F_FFFF_FFFF;
   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [7:0]  active_project;
   logic [37:0] io_oeb;
   logic [6:0]  project_rst;
   logic        busy;
   int          total = 0;
   int          bad = 0;
   project_switch_ctrl_if bus ();
   project_switch_ctrl #(.BASE_ADDR(BASE), .NUM_PROJECTS(7), .IO_PADS(38)) dut (
      .wb_clk_i      (wb_clk_i),
      .wb_rst_i      (wb_rst_i),
      .wb            (bus.slave),
      .active_project(active_project),
      .io_oeb        (io_oeb),
      .project_rst   (project_rst),
      .busy          (busy)
   );
   always #5 wb_clk_i = ~wb_clk_i;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge wb_clk_i);
         #1;
      end
   endtask
   task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rd, output logic got);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      bus.wbs_sel_i = sel;
      got = 1'b0;
      rd  = '0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick(1);
         if (bus.wbs_ack_o) begin
            got = 1'b1;
            rd  = bus.wbs_dat_o;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
   endtask
   task automatic wr(input logic [3:0] off, input logic [31:0] d);
      logic [31:0] r;
      logic        g;
      xfer(BASE + 32'(off), 1'b1, d, 4'hF, r, g);
      check("wr_ack", 64'(g), 64'd1);
   endtask
   task automatic rd(input logic [3:0] off, output logic [31:0] r);
      logic g;
      xfer(BASE + 32'(off), 1'b0, 32'h0, 4'hF, r, g);
      check("rd_ack", 64'(g), 64'd1);
   endtask
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 64) begin
         tick(1);
         n++;
      end
   endtask
   initial begin
      logic [31:0] r;
      logic        g;
      logic        oeb_ok;
      int          n;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = '0;
      bus.wbs_dat_i = '0;
      tick(3);
      check("rst_ack", 64'(bus.wbs_ack_o), 64'd0);
      check("rst_dat", 64'(bus.wbs_dat_o), 64'd0);
      check("rst_ap", 64'(active_project), 64'd0);
      check("rst_oeb", 64'(io_oeb), OEB_ALL);
      check("rst_prst", 64'(project_rst), 64'h7F);
      wb_rst_i = 1'b0;
      n = 0;
      oeb_ok = 1'b1;
      while (busy && n < 64) begin
         tick(1);
         n++;
         if (io_oeb !== 38'h3F_FFFF_FFFF) oeb_ok = 1'b0;
      end
      check("boot_busy_cycles", 64'(n), 64'd19);
      check("boot_oeb_stays", 64'(oeb_ok), 64'd1);
      check("boot_prst", 64'(project_rst), 64'h7E);
      check("boot_ap", 64'(active_project), 64'd0);
      wr(4'h4, 32'h0000_FF00);
      wr(4'hC, 32'h0000_0004);
      rd(4'h4, r);
      check("rd_oeb0", 64'(r), 64'h0000_FF00);
      rd(4'hC, r);
      check("rd_hold", 64'(r), 64'd4);
      wr(4'h0, 32'h0000_0002);
      check("sw2_busy_t1", 64'(busy), 64'd1);
      tick(1);
      check("sw2_oeb_t2", 64'(io_oeb), OEB_ALL);
      check("sw2_prst_t2", 64'(project_rst), 64'h7F);
      tick(5);
      check("sw2_ap_t7", 64'(active_project), 64'd2);
      check("sw2_oeb_t7", 64'(io_oeb), OEB_ALL);
      tick(1);
      check("sw2_oeb_t8", 64'(io_oeb), 64'h3F_0000_FF00);
      check("sw2_prst_t8", 64'(project_rst), 64'h7B);
      check("sw2_busy_t8", 64'(busy), 64'd0);
      wr(4'h0, 32'h0000_0009);
      check("range_busy", 64'(busy), 64'd0);
      rd(4'h0, r);
      check("range_status", 64'(r), 64'h8000_0002);
      check("range_ap", 64'(active_project), 64'd2);
      wr(4'h0, 32'h0000_0001);
      wr(4'h0, 32'h0000_0003);
      wait_idle(n);
      check("busywr_ap", 64'(active_project), 64'd1);
      check("busywr_prst", 64'(project_rst), 64'h7D);
      rd(4'h0, r);
      check("busywr_status", 64'(r), 64'h4000_0001);
      wr(4'h0, 32'h0000_0001);
      rd(4'h0, r);
      check("reswitch_status", 64'(r), 64'h2000_0001);
      wait_idle(n);
      check("reswitch_prst", 64'(project_rst), 64'h7D);
      wr(4'h8, 32'hFFFF_FFC5);
      rd(4'h8, r);
      check("rd_oeb1", 64'(r), 64'h0000_0005);
      wr(4'hC, 32'h0000_0000);
      wr(4'h0, 32'h0000_0004);
      wait_idle(n);
      check("hold0_busy_cycles", 64'(n), 64'd4);
      check("hold0_ap", 64'(active_project), 64'd4);
      check("hold0_oeb", 64'(io_oeb), 64'h05_0000_FF00);
      check("hold0_prst", 64'(project_rst), 64'h6F);
      rd(4'hC, r);
      check("hold0_rd", 64'(r), 64'd0);
      wr(4'hC, 32'h0000_0010);
      wr(4'h0, 32'h0000_0005);
      tick(3);
      wb_rst_i = 1'b1;
      tick(1);
      wb_rst_i = 1'b0;
      check("midrst_ap", 64'(active_project), 64'd0);
      check("midrst_oeb", 64'(io_oeb), OEB_ALL);
      check("midrst_prst", 64'(project_rst), 64'h7F);
      wait_idle(n);
      check("midrst_busy_cycles", 64'(n), 64'd19);
      check("midrst_prst_after", 64'(project_rst), 64'h7E);
      rd(4'h4, r);
      check("midrst_oeb0", 64'(r), 64'hFFFF_FFFF);
      xfer(BASE + 32'hC, 1'b1, 32'h55, 4'h3, r, g);
      check("partial_sel_ack", 64'(g), 64'd1);
      rd(4'hC, r);
      check("partial_sel_ignored", 64'(r), 64'd16);
      xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, r, g);
      check("unmapped_noack", 64'(g), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
